// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM encoding, LCD pin layout, HD44780 commands and 50 MHz timing defaults.
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, SETUP_H, PULSE_H, GAP, SETUP_L, PULSE_L, HOLD} state_e;
  localparam int RS_BIT = 4;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] FUNC_4BIT = 8'h28;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam int SETUP_CYC_DEF      = 2;
  localparam int E_PULSE_CYC_DEF    = 12;
  localparam int NIBBLE_GAP_CYC_DEF = 50;
  localparam int CMD_DELAY_CYC_DEF  = 2500;
  localparam int LONG_DELAY_CYC_DEF = 82000;
  localparam int CNT_W_DEF          = 17;
endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: writes one byte (or a lone high nibble) onto the HD44780 4-bit bus with timed E strobes.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = SETUP_CYC_DEF,
  parameter int E_PULSE_CYC    = E_PULSE_CYC_DEF,
  parameter int NIBBLE_GAP_CYC = NIBBLE_GAP_CYC_DEF,
  parameter int CMD_DELAY_CYC  = CMD_DELAY_CYC_DEF,
  parameter int LONG_DELAY_CYC = LONG_DELAY_CYC_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       wr_long,
  input  logic       wr_nibble,
  output logic       done,
  output logic [4:0] LCD_D,
  output logic       LCD_E
);
  localparam logic [CNT_W-1:0] SETUP_N = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_N = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_N   = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_N   = CNT_W'(CMD_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_N  = CNT_W'(LONG_DELAY_CYC - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic [4:0] lcd_d_q, lcd_d_d;
  logic rs_q, rs_d, long_q, long_d, nib_q, nib_d;
  logic e_q, e_d, done_q, done_d, ready_q, ready_d;
  logic last, take;
  logic [CNT_W-1:0] hold_n;
  assign last   = cnt_q == '0;
  assign take   = wr_valid && ready_q;
  assign hold_n = long_q ? LONG_N : CMD_N;
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 1'b1;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    nib_d   = nib_q;
    lcd_d_d = lcd_d_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (take) begin
        state_d = SETUP_H;
        cnt_d   = SETUP_N;
        rs_d    = wr_rs;
        data_d  = wr_data;
        long_d  = wr_long;
        nib_d   = wr_nibble;
        lcd_d_d = {wr_rs, wr_data[7:4]};
      end
      SETUP_H: if (last) begin
        state_d = PULSE_H;
        cnt_d   = PULSE_N;
      end
      PULSE_H: if (last) begin
        state_d = nib_q ? HOLD : GAP;
        cnt_d   = nib_q ? hold_n : GAP_N;
      end
      GAP: begin
        // low nibble lands one cycle after E falls so the bus keeps hold time
        lcd_d_d = {rs_q, data_q[3:0]};
        if (last) begin
          state_d = SETUP_L;
          cnt_d   = SETUP_N;
        end
      end
      SETUP_L: if (last) begin
        state_d = PULSE_L;
        cnt_d   = PULSE_N;
      end
      PULSE_L: if (last) begin
        state_d = HOLD;
        cnt_d   = hold_n;
      end
      HOLD: if (last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    e_d     = state_d == PULSE_H || state_d == PULSE_L;
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      long_q  <= 1'b0;
      nib_q   <= 1'b0;
      lcd_d_q <= '0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
      nib_q   <= nib_d;
      lcd_d_q <= lcd_d_d;
      e_q     <= e_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end
  assign wr_ready = ready_q;
  assign done     = done_q;
  assign LCD_D    = lcd_d_q;
  assign LCD_E    = e_q;
endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer: directed scenarios on the LCD byte writer with short simulation timings.
module tb_lcd_byte_writer;
  localparam int SU = 2, EP = 3, GP = 4, CD = 10, LG = 30;
  localparam int T_FULL = 2*SU + 2*EP + GP + CD + 1;
  localparam int T_LONG = 2*SU + 2*EP + GP + LG + 1;
  localparam int T_NIB  = SU + EP + CD + 1;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_valid = 1'b0, wr_rs = 1'b0, wr_long = 1'b0, wr_nibble = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready, done, LCD_E;
  logic [4:0] LCD_D;
  int tests = 0, fails = 0;
  int pulses, w0, w1, gap, fall_done, tdone;
  logic [4:0] d0, d1;
  bit stable_bad, ready_busy;

  lcd_byte_writer #(.SETUP_CYC(SU), .E_PULSE_CYC(EP), .NIBBLE_GAP_CYC(GP),
    .CMD_DELAY_CYC(CD), .LONG_DELAY_CYC(LG), .CNT_W(17)) dut (
    .CLK(clk), .RST(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_long(wr_long), .wr_nibble(wr_nibble), .done(done),
    .LCD_D(LCD_D), .LCD_E(LCD_E));

  always #5 clk = ~clk;

  // presents a request at a negedge and returns right after the accepting posedge
  task automatic send(input logic rs, input logic [7:0] d, input logic lg, input logic nb);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests++;
    if (wr_ready !== 1'b1) begin fails++; $display("FAIL send_ready_timeout got %b want 1", wr_ready); end
    wr_rs = rs; wr_data = d; wr_long = lg; wr_nibble = nb; wr_valid = 1'b1;
    @(posedge clk);
  endtask

  // records bus activity cycle by cycle (k=1 is the first cycle after transfer) until done
  task automatic capture(input int limit, input int inj_k, input bit keep);
    int k = 0, lastfall = -1;
    logic pe = 1'b0;
    logic [4:0] pd = '0;
    bit fin = 0;
    pulses = 0; w0 = 0; w1 = 0; gap = 0; fall_done = -1; tdone = -1;
    d0 = 'x; d1 = 'x; stable_bad = 0; ready_busy = 0;
    while (!fin && k < limit) begin
      @(negedge clk);
      k++;
      if (k > 1 && LCD_D !== pd && (LCD_E || pe)) stable_bad = 1;
      if (LCD_E && !pe) begin
        pulses++;
        if (pulses == 1) d0 = LCD_D; else if (pulses == 2) d1 = LCD_D;
      end
      if (LCD_E && pulses == 1) w0++;
      if (LCD_E && pulses == 2) w1++;
      if (!LCD_E && pe) lastfall = k;
      if (!LCD_E && pulses == 1 && lastfall > 0) gap++;
      if (wr_ready && !done) ready_busy = 1;
      if (done) begin tdone = k; fall_done = k - lastfall; fin = 1; end
      if (k == 1 && !keep) wr_valid = 1'b0;
      if (k == inj_k) begin wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hFF; end
      if (k == inj_k + 1 && inj_k > 0) wr_valid = 1'b0;
      pe = LCD_E; pd = LCD_D;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (LCD_E !== 1'b0) begin fails++; $display("FAIL reset_e got %b want 0", LCD_E); end
    tests++; if (LCD_D !== 5'b0) begin fails++; $display("FAIL reset_d got %b want 00000", LCD_D); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", wr_ready); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after got %b want 1", wr_ready); end
  endtask

  task automatic test_data_write();
    send(1'b1, 8'h48, 1'b0, 1'b0);
    capture(200, 0, 0);
    tests++; if (pulses != 2) begin fails++; $display("FAIL data_pulses got %0d want 2", pulses); end
    tests++; if (d0 !== 5'b10100) begin fails++; $display("FAIL data_hi got %b want 10100", d0); end
    tests++; if (d1 !== 5'b11000) begin fails++; $display("FAIL data_lo got %b want 11000", d1); end
    tests++; if (w0 != EP || w1 != EP) begin fails++; $display("FAIL data_width got %0d/%0d want %0d", w0, w1, EP); end
    tests++; if (gap != GP + SU) begin fails++; $display("FAIL data_gap got %0d want %0d", gap, GP + SU); end
    tests++; if (fall_done != CD) begin fails++; $display("FAIL data_fall_done got %0d want %0d", fall_done, CD); end
    tests++; if (tdone != T_FULL) begin fails++; $display("FAIL data_total got %0d want %0d", tdone, T_FULL); end
    tests++; if (stable_bad) begin fails++; $display("FAIL data_d_stable got 1 want 0"); end
    tests++; if (ready_busy) begin fails++; $display("FAIL data_ready_busy got 1 want 0"); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL data_done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_long_cmd();
    send(1'b0, 8'h01, 1'b1, 1'b0);
    capture(200, 0, 0);
    tests++; if (d0 !== 5'b00000 || d1 !== 5'b00001) begin fails++; $display("FAIL long_nibbles got %b %b want 00000 00001", d0, d1); end
    tests++; if (fall_done != LG) begin fails++; $display("FAIL long_fall_done got %0d want %0d", fall_done, LG); end
    tests++; if (tdone != T_LONG) begin fails++; $display("FAIL long_total got %0d want %0d", tdone, T_LONG); end
  endtask

  task automatic test_nibble();
    send(1'b0, 8'h30, 1'b0, 1'b1);
    capture(200, 0, 0);
    tests++; if (pulses != 1) begin fails++; $display("FAIL nib_pulses got %0d want 1", pulses); end
    tests++; if (d0 !== 5'b00011) begin fails++; $display("FAIL nib_d got %b want 00011", d0); end
    tests++; if (w0 != EP) begin fails++; $display("FAIL nib_width got %0d want %0d", w0, EP); end
    tests++; if (fall_done != CD) begin fails++; $display("FAIL nib_fall_done got %0d want %0d", fall_done, CD); end
    tests++; if (tdone != T_NIB) begin fails++; $display("FAIL nib_total got %0d want %0d", tdone, T_NIB); end
  endtask

  task automatic test_back_to_back();
    int total;
    send(1'b1, 8'h65, 1'b0, 1'b0);
    capture(200, 0, 1);
    total = pulses;
    tests++; if (d0 !== 5'b10110 || d1 !== 5'b10101) begin fails++; $display("FAIL b2b_first got %b %b want 10110 10101", d0, d1); end
    tests++; if (wr_ready !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL b2b_ready_done got %b%b want 11", wr_ready, done); end
    tests++; if (ready_busy) begin fails++; $display("FAIL b2b_ready_busy got 1 want 0"); end
    wr_data = 8'h6C;
    @(posedge clk);
    capture(200, 0, 0);
    total += pulses;
    tests++; if (d0 !== 5'b10110 || d1 !== 5'b11100) begin fails++; $display("FAIL b2b_second got %b %b want 10110 11100", d0, d1); end
    tests++; if (tdone != T_FULL) begin fails++; $display("FAIL b2b_total got %0d want %0d", tdone, T_FULL); end
    tests++; if (total != 4) begin fails++; $display("FAIL b2b_pulses got %0d want 4", total); end
  endtask

  task automatic test_busy_ignore();
    bit extra = 0;
    send(1'b0, 8'hA5, 1'b0, 1'b0);
    capture(200, SU + 1, 0);
    tests++; if (d0 !== 5'b01010 || d1 !== 5'b00101) begin fails++; $display("FAIL busy_nibbles got %b %b want 01010 00101", d0, d1); end
    tests++; if (ready_busy) begin fails++; $display("FAIL busy_ready got 1 want 0"); end
    tests++; if (tdone != T_FULL) begin fails++; $display("FAIL busy_total got %0d want %0d", tdone, T_FULL); end
    repeat (5) begin @(negedge clk); if (LCD_E || !wr_ready) extra = 1; end
    tests++; if (extra) begin fails++; $display("FAIL busy_no_queue got 1 want 0"); end
  endtask

  task automatic test_reset_mid_gap();
    send(1'b1, 8'h48, 1'b0, 1'b0);
    wr_valid = 1'b0;
    repeat (SU + EP + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (LCD_E !== 1'b0 || LCD_D !== 5'b0) begin fails++; $display("FAIL midrst_bus got %b %b want 0 00000", LCD_E, LCD_D); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (wr_ready !== 1'b1 || LCD_E !== 1'b0) begin fails++; $display("FAIL midrst_ready got %b e %b want 1 0", wr_ready, LCD_E); end
    send(1'b1, 8'h48, 1'b0, 1'b0);
    capture(200, 0, 0);
    tests++; if (d0 !== 5'b10100 || d1 !== 5'b11000) begin fails++; $display("FAIL midrst_fresh got %b %b want 10100 11000", d0, d1); end
    tests++; if (tdone != T_FULL) begin fails++; $display("FAIL midrst_total got %0d want %0d", tdone, T_FULL); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_long_cmd();
    test_nibble();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
